// File: rtl/qadd_operand_pair.sv
// Pairs two independent operand streams so the adder sees A and B strobed together.
// Latency: 1 edge from the later operand of a pair being buffered to a_out/b_out with pair_en.
// Backpressure: a_ready/b_ready drop only when that side's FIFO is full; hold pauses issue, not fill.

module qadd_pair_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [W-1:0]             push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;

    // Ready is a function of occupancy alone; a same-cycle pop does not free a slot early.
    assign push_ready = (level < LW'(DEPTH));
    assign push       = push_valid & push_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module qadd_operand_pair #(
    parameter int N     = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             a_in,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [N-1:0]             b_in,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic                     hold,
    output logic [N-1:0]             a_out,
    output logic [N-1:0]             b_out,
    output logic                     pair_en,
    output logic [$clog2(DEPTH):0]   a_level,
    output logic [$clog2(DEPTH):0]   b_level,
    output logic [CW-1:0]            pair_cnt
);
    logic [N-1:0] a_head;
    logic [N-1:0] b_head;
    logic         issue;

    // Both heads leave together, which keeps the i-th A aligned with the i-th B.
    assign issue = (a_level != '0) & (b_level != '0) & ~hold;

    qadd_pair_fifo #(.W(N), .DEPTH(DEPTH)) u_a_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (a_valid),
        .push_data  (a_in),
        .push_ready (a_ready),
        .pop        (issue),
        .head       (a_head),
        .level      (a_level)
    );

    qadd_pair_fifo #(.W(N), .DEPTH(DEPTH)) u_b_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (b_valid),
        .push_data  (b_in),
        .push_ready (b_ready),
        .pop        (issue),
        .head       (b_head),
        .level      (b_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out    <= '0;
            b_out    <= '0;
            pair_en  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            pair_en <= issue;
            if (issue) begin
                a_out    <= a_head;
                b_out    <= b_head;
                pair_cnt <= pair_cnt + CW'(1);
            end
        end
    end
endmodule

// File: doc/qadd_operand_pair.md
Name: qadd_operand_pair

Overview:
- Upstream operand-pairing stage for the fixed-point adder (a, a_en, b, b_en; N=64, 2-cycle latency).
- The adder only accepts a pair when a_en and b_en are high in the same cycle. This block takes two independent operand streams, each with a valid/ready handshake, and buffers each stream in its own FIFO.
- When both FIFOs hold data it issues exactly one aligned pair per cycle, driving a_en and b_en together.

Parameters:
- N, 64, operand width in bits; matches the adder's N.
- DEPTH, 4, entries per operand FIFO; must be a power of 2 and at least 2.
- CW, 32, width of the issued-pair counter.

Ports:
- clk  input  1  clock; all logic is on posedge.
- rst  input  1  synchronous, active-high reset.
- a_in  input  N  operand A data.
- a_valid  input  1  operand A is offered this cycle.
- a_ready  output  1  the A FIFO can accept data this cycle.
- b_in  input  N  operand B data.
- b_valid  input  1  operand B is offered this cycle.
- b_ready  output  1  the B FIFO can accept data this cycle.
- hold  input  1  when high, pair issue is suppressed; FIFOs still fill.
- a_out  output  N  paired operand A; drives the adder's a.
- b_out  output  N  paired operand B; drives the adder's b.
- pair_en  output  1  pair strobe; drives both the adder's a_en and b_en.
- a_level  output  $clog2(DEPTH)+1  A FIFO occupancy, 0..DEPTH.
- b_level  output  $clog2(DEPTH)+1  B FIFO occupancy, 0..DEPTH.
- pair_cnt  output  CW  count of issued pairs; wraps modulo 2^CW.

Behaviour:
- Reset, applied at a clock edge while rst=1:
  - Read/write pointers and levels go to 0.
  - a_out, b_out and pair_cnt go to 0; pair_en goes to 0.
  - a_ready and b_ready go to 1 in the cycle after reset.
  - FIFO storage contents are don't-care.
- Reset mid-operation discards all buffered operands. No pair_en pulse is produced in the cycle after the rst edge.
- Ready is combinational from level only: a_ready = (a_level < DEPTH); b_ready likewise. Ready does not look ahead to a same-cycle pop.
- Push A happens when a_valid & a_ready: a_in is written at the A write pointer, and the pointer increments, wrapping DEPTH-1 -> 0. Push B is identical.
- Issue condition: issue = (a_level != 0) & (b_level != 0) & ~hold.
- On issue, both FIFOs pop their head in the same cycle:
  - a_out and b_out are registered from the A and B heads.
  - pair_en is registered to 1.
  - pair_cnt increments by 1.
- When issue is 0:
  - pair_en is registered to 0.
  - a_out and b_out hold their last values.
  - pair_cnt holds.
- Level update per FIFO:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is possible only when level < DEPTH.
- Latency: an operand accepted at edge k whose partner is already buffered appears on a_out/b_out with pair_en=1 after edge k+1. The block adds 1 register stage, so accept to adder result is 3 edges.
- Throughput is 1 pair per cycle sustained when both streams are valid every cycle and hold=0.
- Ordering: pairs are strictly FIFO-ordered per stream. The i-th accepted A is always paired with the i-th accepted B.
- Empty side: if one FIFO is empty, no issue occurs. The other FIFO fills up to DEPTH, then deasserts its ready.
- A valid offered while ready=0 is not accepted. The source must hold its data; the block captures nothing.
- hold=1: pops stop immediately, so pair_en=0 in the cycle after the edge where hold was sampled high. Pushes continue. Issue resumes in the cycle hold is seen low.
- pair_cnt wraps from 2^CW-1 to 0 without any flag.
- a_out/b_out transfer bit patterns unmodified; no sign handling.

Test Plan:
- Reset, then idle. Expect a_ready=b_ready=1, pair_en=0, levels 0, pair_cnt=0, a_out=b_out=0.
- Push A=0x10 at edge 1 and B=0x20 at edge 4. Expect pair_en=1 only after edge 5, with a_out=0x10 and b_out=0x20; levels return to 0; pair_cnt=1.
- Push A values 1..5 with b_valid=0 and DEPTH=4. Expect a_level=4 and a_ready=0 after the 4th push; value 5 is not accepted while ready is low. Then push B values 100..103. Expect pairs (1,100), (2,101), (3,102), (4,103) on consecutive cycles; the held value 5 is accepted once a_ready rises.
- Both streams valid every cycle with A=i and B=2i for i=0..15, hold=0. Expect 16 consecutive pair_en cycles, each with b_out=2*a_out, and pair_cnt=16.
- Fill both FIFOs with 3 entries, assert hold for 5 cycles, then release. Expect pair_en=0 during hold and levels stay at 3. After release, expect 3 consecutive pairs in order.
- Assert rst with 2 A and 1 B buffered and an issue pending. Expect pair_en=0 after the reset edge, levels 0, pair_cnt=0. The next pushed pair issues correctly, with no stale data.
